// File: rtl/mul_div_unit.sv
// Iterative signed multiply / divide unit.
// Multiply: radix-2 Booth, one step per clock, 64-bit product on Z_HI_out:Z_LO_out.
// Divide: restoring division on operand magnitudes with the signs fixed up at the
// end; quotient on Z_LO_out, remainder on Z_HI_out. A zero divisor finishes
// after a single cycle and raises div_by_zero.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Z_HI_out,
  output logic [WIDTH-1:0] Z_LO_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state_q, state_d;

  // Working registers shared by both operations:
  //   acc_q : Booth partial product (sign-extended) / division remainder
  //   q_q   : Booth multiplier being shifted out / dividend-then-quotient
  //   m_q   : sign-extended multiplicand / zero-extended divisor magnitude
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] q_q;
  logic             qm1_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH-1:0] a_q;
  logic             op_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic             dz_pend_q;
  logic [CNT_W-1:0] cnt_q;

  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] z_hi_q;
  logic [WIDTH-1:0] z_lo_q;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_trial;
  logic [WIDTH:0]   acc_iter;
  logic [WIDTH-1:0] q_iter;
  logic             qm1_iter;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_mag = A_in[WIDTH-1] ? -A_in : A_in;
  assign b_mag = B_in[WIDTH-1] ? -B_in : B_in;

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples values from before the edge, regardless of block ordering.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start is only honoured in IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (dz_pend_q || cnt_q == LAST_ITER) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: busy drops in the FIN cycle of a divide-by-zero because
  // done is already asserted there.
  always_comb begin
    busy = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      FIN:     busy = !dbz_q;
      default: busy = 1'b0;
    endcase
  end

  // One iteration step for the selected operation.
  always_comb begin
    booth_sum = acc_q;
    rem_shift = '0;
    rem_trial = '0;
    acc_iter  = acc_q;
    q_iter    = q_q;
    qm1_iter  = qm1_q;
    if (op_q) begin
      rem_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
      rem_trial = rem_shift - m_q;
      qm1_iter  = 1'b0;
      if (!rem_trial[WIDTH]) begin
        acc_iter = rem_trial;
        q_iter   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_iter = rem_shift;
        q_iter   = {q_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      unique case ({q_q[0], qm1_q})
        2'b01:   booth_sum = acc_q + m_q;
        2'b10:   booth_sum = acc_q - m_q;
        default: booth_sum = acc_q;
      endcase
      acc_iter = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      q_iter   = {booth_sum[0], q_q[WIDTH-1:1]};
      qm1_iter = q_q[0];
    end
  end

  // Sign correction of the unsigned division result; the most negative
  // quotient wraps naturally in two's complement.
  always_comb begin
    quot_fix = neg_quot_q ? -q_q : q_q;
    rem_fix  = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  // Datapath: operand capture, iteration, and result / flag registers.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      acc_q      <= '0;
      q_q        <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      a_q        <= '0;
      op_q       <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_pend_q  <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      z_hi_q     <= '0;
      z_lo_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q      <= '0;
            qm1_q      <= 1'b0;
            q_q        <= op ? a_mag : A_in;
            m_q        <= op ? {1'b0, b_mag} : {B_in[WIDTH-1], B_in};
            a_q        <= A_in;
            op_q       <= op;
            neg_quot_q <= A_in[WIDTH-1] ^ B_in[WIDTH-1];
            neg_rem_q  <= A_in[WIDTH-1];
            dz_pend_q  <= op && (B_in == '0);
            cnt_q      <= '0;
            dbz_q      <= 1'b0;
          end
        end
        RUN: begin
          if (dz_pend_q) begin
            z_lo_q <= '1;
            z_hi_q <= a_q;
            dbz_q  <= 1'b1;
            done_q <= 1'b1;
          end else begin
            acc_q <= acc_iter;
            q_q   <= q_iter;
            qm1_q <= qm1_iter;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIN: begin
          if (dz_pend_q) begin
            done_q <= 1'b0;
          end else begin
            z_hi_q <= op_q ? rem_fix  : acc_q[WIDTH-1:0];
            z_lo_q <= op_q ? quot_fix : q_q;
            done_q <= 1'b1;
          end
        end
        default: done_q <= 1'b0;
      endcase
    end
  end

  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign Z_HI_out    = z_hi_q;
  assign Z_LO_out    = z_lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected results,
// a monitor pops and compares each time done is seen.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clock;
  logic         clear;
  logic         start;
  logic         op;
  logic [W-1:0] A_in;
  logic [W-1:0] B_in;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] Z_HI_out;
  logic [W-1:0] Z_LO_out;

  mul_div_unit #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .A_in        (A_in),
    .B_in        (B_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .Z_HI_out    (Z_HI_out),
    .Z_LO_out    (Z_LO_out)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           start_cyc;
    int           lat;
  } exp_t;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clock) begin
    if (clear && done) begin
      check("busy_with_done", 64'(busy), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("z_hi", 64'(Z_HI_out), 64'(e.hi));
        check("z_lo", 64'(Z_LO_out), 64'(e.lo));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dz));
        check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
      end
    end
  end

  // Issue one operation and push its expected result; operands are scrambled
  // right after the accepting edge to show they were captured.
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi, input logic [W-1:0] lo,
                       input logic dz, input int lat);
    exp_t e;
    @(negedge clock);
    start = 1'b1;
    op    = o;
    A_in  = a;
    B_in  = b;
    e.hi = hi; e.lo = lo; e.dz = dz; e.start_cyc = cyc + 1; e.lat = lat;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    op    = ~o;
    A_in  = 32'hDEADBEEF;
    B_in  = 32'h0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[2] = '{1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[3] = '{1'b1, 32'hFFFFFFEF, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFD};
    vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2};
    vecs[6] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E};
    vecs[7] = '{1'b1, 32'd5,        32'd7,        32'h00000005, 32'h00000000};

    clear = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    A_in  = '0;
    B_in  = '0;

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_zhi", 64'(Z_HI_out), 64'd0);
    check("rst_zlo", 64'(Z_LO_out), 64'd0);
    clear = 1'b1;

    // 7 * -3, then results must hold while idle.
    issue(1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
    check("busy_running", 64'(busy), 64'd1);
    wait_idle();
    repeat (3) @(negedge clock);
    check("hold_zhi", 64'(Z_HI_out), 64'hFFFFFFFF);
    check("hold_zlo", 64'(Z_LO_out), 64'hFFFFFFEB);
    check("hold_busy", 64'(busy), 64'd0);

    // Start re-pulsed mid-operation with other operands is ignored.
    issue(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33);
    repeat (4) @(negedge clock);
    start = 1'b1; op = 1'b1; A_in = 32'd9; B_in = 32'd0;
    @(negedge clock);
    start = 1'b0;
    check("ignored_start_busy", 64'(busy), 64'd1);
    check("ignored_start_dbz", 64'(div_by_zero), 64'd0);
    wait_idle();

    // Directed table.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, 33);
      wait_idle();
    end

    // Divide by zero: one-cycle latency, flag held until the next start.
    issue(1'b1, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b1, 1);
    wait_idle();
    repeat (3) @(negedge clock);
    check("dbz_held", 64'(div_by_zero), 64'd1);
    issue(1'b1, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 33);
    check("dbz_cleared_on_start", 64'(div_by_zero), 64'd0);
    wait_idle();

    // 3 * 4 with a re-pulsed start at cycle 5 and clear at cycle 10.
    issue(1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33);
    repeat (3) @(negedge clock);
    start = 1'b1; op = 1'b0; A_in = 32'd9; B_in = 32'd9;
    @(negedge clock);
    start = 1'b0;
    check("c5_busy", 64'(busy), 64'd1);
    repeat (4) @(negedge clock);
    #2 clear = 1'b0;
    #1;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_zhi", 64'(Z_HI_out), 64'd0);
    check("clr_zlo", 64'(Z_LO_out), 64'd0);
    check("clr_dbz", 64'(div_by_zero), 64'd0);
    sb.delete();
    @(negedge clock);
    clear = 1'b1;
    issue(1'b0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset inputs.
REQ-002 Parameter: WIDTH, 32, operand width; all arithmetic rules below are stated for WIDTH=32.
REQ-003 Port: clock  input  1  rising-edge clock.
REQ-004 Port: clear  input  1  asynchronous active-low reset.
REQ-005 Port: start  input  1  request to begin an operation; sampled on the rising edge.
REQ-006 Port: op  input  1  operation select: 0 = signed multiply, 1 = signed divide.
REQ-007 Port: A_in  input  WIDTH  multiplicand or dividend, taken from the Y register output.
REQ-008 Port: B_in  input  WIDTH  multiplier or divisor, taken from the datapath bus.
REQ-009 Port: busy  output  1  high while an operation is in progress.
REQ-010 Port: done  output  1  one-cycle pulse marking the edge at which the results become valid.
REQ-011 Port: div_by_zero  output  1  high when the last divide had B_in = 0; held until the next accepted start.
REQ-012 Port: Z_HI_out  output  WIDTH  product high word, or divide remainder; feeds the Z_HI bus source.
REQ-013 Port: Z_LO_out  output  WIDTH  product low word, or divide quotient; feeds the Z_LO bus source.

Function
REQ-014 The state machine SHALL have three states: IDLE, RUN, FIN.
- IDLE to RUN on start=1.
- RUN to FIN after the 32nd iteration, or immediately for a divide by zero.
- FIN to IDLE unconditionally.
REQ-015 On the accepting edge E0 the block SHALL register A_in, B_in and op, clear the iteration counter, set busy=1 and clear div_by_zero.
REQ-016 Later changes to A_in, B_in or op SHALL NOT affect the operation in progress.
REQ-017 Timing for a normal operation:
- One iteration per edge, on E1 through E32.
- At E33: results loaded into Z_HI_out/Z_LO_out, done=1, busy=0.
- At E34: done=0.
- Start-to-done latency is 33 cycles.
REQ-018 Multiply SHALL be signed radix-2 Booth over 32 iterations, producing a 64-bit two's-complement product: Z_HI_out = bits 63:32, Z_LO_out = bits 31:0.
REQ-019 Divide SHALL be signed, truncating toward zero.
- Quotient to Z_LO_out; remainder to Z_HI_out.
- The remainder takes the sign of the dividend, or is zero.
- Unsigned restoring or non-restoring iteration on magnitudes, with sign correction applied at E33.
REQ-020 Divide by zero (op=1, B_in=0 at E0):
- No iterations are performed.
- At E1: Z_LO_out=32'hFFFFFFFF, Z_HI_out=A_in as captured, div_by_zero=1, done=1, busy=0.
REQ-021 Overflow divide 32'h80000000 / 32'hFFFFFFFF SHALL give Z_LO_out=32'h80000000 and Z_HI_out=0 (two's-complement wrap), with no error flag.
REQ-022 start while busy=1, or in FIN, SHALL be ignored, with no effect on state, operands or outputs.
REQ-023 Z_HI_out and Z_LO_out SHALL hold their last results from done until the next result load; intermediate iteration values SHALL NOT appear on them.
REQ-024 done and busy SHALL never be high in the same cycle.

Reset
REQ-025 clear=0 SHALL asynchronously force the following, regardless of the current state, including mid-operation:
- state=IDLE, counter=0;
- busy=0, done=0, div_by_zero=0;
- Z_HI_out=0, Z_LO_out=0.
REQ-026 After clear returns to 1, the first start edge SHALL be accepted normally.

Verification
REQ-027 Multiply: A_in=7, B_in=32'hFFFFFFFD (-3), start -> done exactly 33 cycles later; Z_HI_out=32'hFFFFFFFF, Z_LO_out=32'hFFFFFFEB.
REQ-028 Multiply: A_in=B_in=32'h80000000 -> Z_HI_out=32'h40000000, Z_LO_out=32'h00000000.
REQ-029 Divide: A_in=32'hFFFFFFEF (-17), B_in=5 -> Z_LO_out=32'hFFFFFFFD (-3), Z_HI_out=32'hFFFFFFFE (-2), div_by_zero=0.
REQ-030 Divide by zero: A_in=100, B_in=0 -> done one cycle after start; Z_LO_out=32'hFFFFFFFF, Z_HI_out=32'h00000064, div_by_zero=1.
REQ-031 Divide overflow: A_in=32'h80000000, B_in=32'hFFFFFFFF -> Z_LO_out=32'h80000000, Z_HI_out=0.
REQ-032 Multiply 3*4, with start re-pulsed at cycle 5 and clear pulsed low at cycle 10 -> the cycle-5 start is ignored; at cycle 10 all outputs go to 0 and busy=0; a subsequent start of 3*4 gives Z_LO_out=12 after 33 cycles.
